// File: rtl/div_pkg.sv
// Shared widths and FSM encodings for the iterative restoring divider.
package div_pkg;

    localparam int DIVIDEND_W = 10;
    localparam int DIVISOR_W  = 5;
    localparam int CNT_W      = $clog2(DIVIDEND_W);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// Single combinational restoring-division stage.
// Shifts the next dividend bit into the partial remainder.
// Subtracts the divisor when the shifted value is large enough.
module div_step #(
    parameter int DIVISOR_W = div_pkg::DIVISOR_W
) (
    input  logic [DIVISOR_W:0]   p_i,
    input  logic                 bit_i,
    input  logic [DIVISOR_W-1:0] divisor_i,
    output logic [DIVISOR_W:0]   p_o,
    output logic                 q_o
);

    logic [DIVISOR_W:0] t;

    // P < divisor holds between steps, so the incoming MSB is always zero
    // and only the low bits are shifted up.
    logic unused_p_msb;
    assign unused_p_msb = p_i[DIVISOR_W];

    // Trial subtraction: keep the difference when it does not underflow.
    always_comb begin
        t   = {p_i[DIVISOR_W-1:0], bit_i};
        p_o = t;
        q_o = 1'b0;
        if (t >= {1'b0, divisor_i}) begin
            p_o = t - {1'b0, divisor_i};
            q_o = 1'b1;
        end
    end

endmodule

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
// The FSM sequences the operation. Operand and result registers live here.
// The per-bit arithmetic lives in div_step.
module seq_divider
    import div_pkg::*;
#(
    parameter int DIVIDEND_W = div_pkg::DIVIDEND_W,
    parameter int DIVISOR_W  = div_pkg::DIVISOR_W
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  ready,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    localparam int CW = $clog2(DIVIDEND_W);

    div_state_e            state_q, state_d;
    logic [CW-1:0]         cnt_q,   cnt_d;
    logic [DIVIDEND_W-1:0] dvd_q,   dvd_d;    // dividend, shifted out MSB-first
    logic [DIVISOR_W-1:0]  dvs_q,   dvs_d;
    logic [DIVIDEND_W-1:0] quot_q,  quot_d;   // quotient, shifted in at LSB
    logic [DIVISOR_W:0]    p_q,     p_d;      // partial remainder
    logic                  dbz_q,   dbz_d;

    logic [DIVISOR_W:0]    step_p;
    logic                  step_q;

    div_step #(.DIVISOR_W(DIVISOR_W)) u_step (
        .p_i       (p_q),
        .bit_i     (dvd_q[DIVIDEND_W-1]),
        .divisor_i (dvs_q),
        .p_o       (step_p),
        .q_o       (step_q)
    );

    // All outputs come straight from registers.
    assign ready       = (state_q == S_IDLE);
    assign done        = (state_q == S_DONE);
    assign quotient    = quot_q;
    assign remainder   = p_q[DIVISOR_W-1:0];
    assign div_by_zero = dbz_q;

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            quot_q  <= '0;
            p_q     <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            quot_q  <= quot_d;
            p_q     <= p_d;
            dbz_q   <= dbz_d;
        end
    end

    // Next-state and datapath update; start is only looked at in IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        quot_d  = quot_q;
        p_d     = p_q;
        dbz_d   = dbz_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    dvd_d = dividend;
                    dvs_d = divisor;
                    p_d   = '0;
                    if (divisor == '0) begin
                        // No iterations: report saturated quotient immediately.
                        quot_d  = '1;
                        dbz_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        quot_d  = '0;
                        dbz_d   = 1'b0;
                        cnt_d   = CW'(DIVIDEND_W - 1);
                        state_d = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                dvd_d  = {dvd_q[DIVIDEND_W-2:0], 1'b0};
                quot_d = {quot_q[DIVIDEND_W-2:0], step_q};
                p_d    = step_p;
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed-vector bench for seq_divider.
module tb_seq_divider;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [9:0] dividend = '0;
    logic [4:0] divisor = '0;
    logic       ready;
    logic       done;
    logic [9:0] quotient;
    logic [4:0] remainder;
    logic       div_by_zero;

    int pass_cnt = 0;
    int total_cnt = 0;

    seq_divider dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .ready       (ready),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clock = ~clock;

    // Caller is positioned 1 time unit after a rising edge.
    // lat counts edges after the accept edge until done is seen.
    task automatic run_op(input logic [9:0] a, input logic [4:0] b,
                          output int lat, output logic [9:0] q,
                          output logic [4:0] r, output logic z,
                          output logic pulse_low);
        int guard;
        guard = 0;
        while (ready !== 1'b1 && guard < 50) begin
            @(posedge clock); #1; guard++;
        end
        dividend = a; divisor = b; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 30) begin
            @(posedge clock); #1; lat++;
        end
        q = quotient; r = remainder; z = div_by_zero;
        @(posedge clock); #1;
        pulse_low = (done === 1'b0);
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clock);
        #1;
        total_cnt++;
        if ({ready, done, quotient, remainder, div_by_zero} !== {1'b1, 1'b0, 10'd0, 5'd0, 1'b0})
            $display("FAIL reset_state: got rdy=%b done=%b q=%0d r=%0d dbz=%b, want 1 0 0 0 0",
                     ready, done, quotient, remainder, div_by_zero);
        else pass_cnt++;
        reset = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_basic();
        int va[5] = '{400, 961, 1000, 1023, 0};
        int vb[5] = '{20, 31, 7, 1, 5};
        int vq[5] = '{20, 31, 142, 1023, 0};
        int vr[5] = '{0, 0, 6, 0, 0};
        int lat;
        logic [9:0] q;
        logic [4:0] r;
        logic z, pl;
        for (int i = 0; i < 5; i++) begin
            run_op(10'(va[i]), 5'(vb[i]), lat, q, r, z, pl);
            total_cnt++;
            if (lat !== 10) $display("FAIL basic_latency %0d/%0d: got %0d, want 10", va[i], vb[i], lat);
            else pass_cnt++;
            total_cnt++;
            if (q !== 10'(vq[i])) $display("FAIL basic_quotient %0d/%0d: got %0d, want %0d", va[i], vb[i], q, vq[i]);
            else pass_cnt++;
            total_cnt++;
            if (r !== 5'(vr[i])) $display("FAIL basic_remainder %0d/%0d: got %0d, want %0d", va[i], vb[i], r, vr[i]);
            else pass_cnt++;
            total_cnt++;
            if (z !== 1'b0) $display("FAIL basic_dbz %0d/%0d: got %b, want 0", va[i], vb[i], z);
            else pass_cnt++;
            total_cnt++;
            if (pl !== 1'b1) $display("FAIL basic_done_pulse %0d/%0d: done still high, want one cycle", va[i], vb[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_div_zero();
        int lat;
        logic [9:0] q;
        logic [4:0] r;
        logic z, pl;
        run_op(10'd5, 5'd0, lat, q, r, z, pl);
        total_cnt++;
        if (lat > 1) $display("FAIL dbz_latency: got %0d, want at most 1", lat);
        else pass_cnt++;
        total_cnt++;
        if ({q, r, z} !== {10'h3FF, 5'd0, 1'b1})
            $display("FAIL dbz_results: got q=%h r=%0d dbz=%b, want 3ff 0 1", q, r, z);
        else pass_cnt++;
        total_cnt++;
        if (pl !== 1'b1) $display("FAIL dbz_done_pulse: done still high, want one cycle");
        else pass_cnt++;
    endtask

    task automatic test_busy_start();
        int lat;
        // Accept 1000/7 at edge N.
        dividend = 10'd1000; divisor = 5'd7; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        total_cnt++;
        if (ready !== 1'b0) $display("FAIL busy_ready: got %b, want 0", ready);
        else pass_cnt++;
        // Third BUSY cycle begins after edge N+2; this start is sampled at N+3.
        @(posedge clock); #1;
        @(posedge clock); #1;
        dividend = 10'd20; divisor = 5'd20; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        lat = 3;
        while (done !== 1'b1 && lat < 30) begin
            @(posedge clock); #1; lat++;
        end
        total_cnt++;
        if (lat !== 10) $display("FAIL busy_latency: got %0d, want 10", lat);
        else pass_cnt++;
        total_cnt++;
        if ({quotient, remainder} !== {10'd142, 5'd6})
            $display("FAIL busy_results: got q=%0d r=%0d, want 142 6", quotient, remainder);
        else pass_cnt++;
        for (int k = 0; k < 3; k++) begin
            @(posedge clock); #1;
            total_cnt++;
            if ({done, quotient, remainder} !== {1'b0, 10'd142, 5'd6})
                $display("FAIL hold_cycle%0d: got done=%b q=%0d r=%0d, want 0 142 6", k, done, quotient, remainder);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        logic [9:0] q;
        logic [4:0] r;
        logic z, pl;
        dividend = 10'd961; divisor = 5'd31; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        // Fourth BUSY cycle begins after edge N+3.
        repeat (3) begin @(posedge clock); #1; end
        reset = 1'b1;
        #1;
        total_cnt++;
        if ({ready, done, quotient, remainder, div_by_zero} !== {1'b1, 1'b0, 10'd0, 5'd0, 1'b0})
            $display("FAIL midreset_state: got rdy=%b done=%b q=%0d r=%0d dbz=%b, want 1 0 0 0 0",
                     ready, done, quotient, remainder, div_by_zero);
        else pass_cnt++;
        @(posedge clock); #1;
        reset = 1'b0;
        run_op(10'd400, 5'd20, lat, q, r, z, pl);
        total_cnt++;
        if (lat !== 10) $display("FAIL midreset_latency: got %0d, want 10", lat);
        else pass_cnt++;
        total_cnt++;
        if ({q, r, z} !== {10'd20, 5'd0, 1'b0})
            $display("FAIL midreset_results: got q=%0d r=%0d dbz=%b, want 20 0 0", q, r, z);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_div_zero();
        test_busy_start();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
